// File: rtl/mips_mem_master_if.sv
// Request/response and DataMem bus bundle for mips_mem_master.
// The master modport is the block's own view; slave is the pipeline/memory side.
interface mips_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signext;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic [31:0] DataMem_In;
    logic        DataMem_Ready;
    logic        DataMem_Read;
    logic [3:0]  DataMem_Write;
    logic [29:0] DataMem_Address;
    logic [31:0] DataMem_Out;

    modport master (
        input  req_valid, req_write, req_size, req_signext, req_addr, req_wdata,
        input  DataMem_In, DataMem_Ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error,
        output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out
    );

    modport slave (
        output req_valid, req_write, req_size, req_signext, req_addr, req_wdata,
        output DataMem_In, DataMem_Ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error,
        input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out
    );
endinterface

// File: rtl/mips_mem_master.sv
// MIPS32 data-memory initiator: byte/half/word loads and stores onto a big-endian,
// word-addressed, byte-strobed DataMem bus with alignment checks and a ready timeout.
module mips_mem_master #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clock,
    input  logic              reset,
    mips_mem_master_if.master bus
);
    typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_t;

    state_t      stateQ, stateD;
    logic [1:0]  offsetQ, sizeQ;
    logic        signextQ, errorQ;
    logic [3:0]  strobeQ;
    logic [29:0] wordAddrQ;
    logic [31:0] outDataQ, rdataQ;
    logic [7:0]  countQ;

    logic        reqError, timeoutHit;
    logic [3:0]  reqStrobe;
    logic [31:0] reqData, loadData;
    logic [7:0]  loadByte;
    logic [15:0] loadHalf;

    assign timeoutHit = (countQ == 8'(TIMEOUT - 1));

    always_comb begin
        unique case (bus.req_size)
            2'b00:   reqError = 1'b0;
            2'b01:   reqError = bus.req_addr[0];
            2'b10:   reqError = |bus.req_addr[1:0];
            default: reqError = 1'b1;
        endcase
    end

    // Byte offset 0 is the most significant lane.
    always_comb begin
        reqStrobe = 4'b1111;
        reqData   = bus.req_wdata;
        unique case (bus.req_size)
            2'b00: begin
                reqStrobe = 4'b1000 >> bus.req_addr[1:0];
                reqData   = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                reqStrobe = bus.req_addr[1] ? 4'b0011 : 4'b1100;
                reqData   = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        unique case (offsetQ)
            2'd0:    loadByte = bus.DataMem_In[31:24];
            2'd1:    loadByte = bus.DataMem_In[23:16];
            2'd2:    loadByte = bus.DataMem_In[15:8];
            default: loadByte = bus.DataMem_In[7:0];
        endcase
        loadHalf = offsetQ[1] ? bus.DataMem_In[15:0] : bus.DataMem_In[31:16];
        unique case (sizeQ)
            2'b00:   loadData = signextQ ? {{24{loadByte[7]}}, loadByte} : {24'b0, loadByte};
            2'b01:   loadData = signextQ ? {{16{loadHalf[15]}}, loadHalf} : {16'b0, loadHalf};
            default: loadData = bus.DataMem_In;
        endcase
    end

    always_comb begin
        stateD = stateQ;
        unique case (stateQ)
            StIdle: begin
                if (bus.req_valid) begin
                    if (reqError)           stateD = StResp;
                    else if (bus.req_write) stateD = StWrite;
                    else                    stateD = StRead;
                end
            end
            StRead:  if (bus.DataMem_Ready || timeoutHit) stateD = StResp;
            StWrite: stateD = StResp;
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) stateQ <= StIdle;
        else        stateQ <= stateD;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            offsetQ   <= '0;
            sizeQ     <= '0;
            signextQ  <= 1'b0;
            errorQ    <= 1'b0;
            strobeQ   <= '0;
            wordAddrQ <= '0;
            outDataQ  <= '0;
            rdataQ    <= '0;
            countQ    <= '0;
        end else if (stateQ == StIdle && bus.req_valid) begin
            offsetQ  <= bus.req_addr[1:0];
            sizeQ    <= bus.req_size;
            signextQ <= bus.req_signext;
            errorQ   <= reqError;
            rdataQ   <= '0;
            countQ   <= '0;
            // Rejected requests leave the bus registers untouched.
            if (!reqError) wordAddrQ <= bus.req_addr[31:2];
            if (!reqError && bus.req_write) begin
                strobeQ  <= reqStrobe;
                outDataQ <= reqData;
            end
        end else if (stateQ == StRead) begin
            if (bus.DataMem_Ready) rdataQ <= loadData;
            else if (timeoutHit)   errorQ <= 1'b1;
            else                   countQ <= countQ + 8'd1;
        end
    end

    assign bus.req_ready       = (stateQ == StIdle);
    assign bus.rsp_valid       = (stateQ == StResp);
    assign bus.rsp_rdata       = rdataQ;
    assign bus.rsp_error       = errorQ;
    assign bus.DataMem_Read    = (stateQ == StRead);
    assign bus.DataMem_Write   = (stateQ == StWrite) ? strobeQ : 4'b0000;
    assign bus.DataMem_Address = wordAddrQ;
    assign bus.DataMem_Out     = outDataQ;
endmodule

// File: tb/tb_mips_mem_master.sv
// Randomised self-checking bench for mips_mem_master against a byte-level memory model.
module tb_mips_mem_master;
    localparam int TO = 4;

    logic clock = 1'b0;
    logic reset;

    mips_mem_master_if bus();

    mips_mem_master #(.TIMEOUT(TO)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checkCount = 0;
    int passCount  = 0;

    logic [7:0]  refMem [256];
    logic [31:0] busMem [64];
    int          respDelay = 0;
    bit          forceJunk = 1'b0;

    int          lat, nRd, nWr;
    logic [31:0] rd, dout;
    logic        er;
    logic [3:0]  strb;
    logic [29:0] waddr;

    // ---------------- reference model ----------------
    function automatic int sizeBytes(logic [1:0] sz);
        return 1 << sz;
    endfunction

    function automatic bit modelError(logic [1:0] sz, logic [31:0] a);
        if (sz == 2'b11) return 1'b1;
        return (int'(a[7:0]) % sizeBytes(sz)) != 0;
    endfunction

    function automatic bit modelTimeout(logic wr, bit err, int dly);
        return !err && !wr && (dly > TO - 2);
    endfunction

    function automatic int modelLatency(logic wr, bit err, int dly);
        if (err) return 1;
        if (wr) return 2;
        if (dly <= TO - 2) return 3 + dly;
        return TO + 1;
    endfunction

    function automatic logic [31:0] modelLoad(logic [1:0] sz, logic sx, logic [31:0] a);
        int n = sizeBytes(sz);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(refMem[(int'(a[7:0]) + i) % 256]);
        if (sx && n < 4 && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    function automatic void modelStore(logic [1:0] sz, logic [31:0] a, logic [31:0] wd);
        int n = sizeBytes(sz);
        for (int i = 0; i < n; i++)
            refMem[(int'(a[7:0]) + i) % 256] = 8'(wd >> (8 * (n - 1 - i)));
    endfunction

    function automatic logic [3:0] modelStrobe(logic [1:0] sz, logic [31:0] a);
        logic [3:0] s = '0;
        if (sz == 2'b11) return s;
        for (int i = 0; i < sizeBytes(sz); i++) s[3 - (int'(a[1:0]) + i)] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] modelOut(logic [1:0] sz, logic [31:0] wd);
        int n = sizeBytes(sz);
        logic [31:0] o = '0;
        for (int lane = 0; lane < 4; lane++)
            o[8 * (3 - lane) +: 8] = 8'(wd >> (8 * ((n - 1) - (lane % n))));
        return o;
    endfunction

    function automatic logic [31:0] refWord(int i);
        return {refMem[4 * i], refMem[4 * i + 1], refMem[4 * i + 2], refMem[4 * i + 3]};
    endfunction

    function automatic void setWord(int i, logic [31:0] v);
        busMem[i] = v;
        for (int j = 0; j < 4; j++) refMem[4 * i + j] = v[8 * (3 - j) +: 8];
    endfunction

    // ---------------- memory responder ----------------
    // Ready follows respDelay+1 consecutive cycles of Read; one pulse per read burst.
    initial begin : responder
        int          run;
        logic        rdPrev;
        logic [31:0] fetched;
        run = 0;
        bus.DataMem_Ready = 1'b0;
        bus.DataMem_In    = '0;
        forever begin
            @(negedge clock);
            for (int b = 0; b < 4; b++)
                if (bus.DataMem_Write[b])
                    busMem[bus.DataMem_Address[5:0]][8 * b +: 8] = bus.DataMem_Out[8 * b +: 8];
            rdPrev  = bus.DataMem_Read;
            run     = rdPrev ? run + 1 : 0;
            fetched = busMem[bus.DataMem_Address[5:0]];
            @(posedge clock);
            #1;
            if (forceJunk) begin
                bus.DataMem_Ready = 1'b1;
                bus.DataMem_In    = $urandom;
            end else if (rdPrev && run == respDelay + 1) begin
                bus.DataMem_Ready = 1'b1;
                bus.DataMem_In    = fetched;
            end else begin
                bus.DataMem_Ready = 1'b0;
                bus.DataMem_In    = $urandom;
            end
        end
    end

    // ---------------- transaction driver ----------------
    task automatic runReq(input logic wr, input logic [1:0] sz, input logic sx,
                          input logic [31:0] a, input logic [31:0] wd, input int dly,
                          output int oLat, output logic [31:0] oRd, output logic oEr,
                          output int oRead, output int oWrite, output logic [3:0] oStrb,
                          output logic [31:0] oOut, output logic [29:0] oAddr);
        int guard;
        guard = 0;
        oLat = -1; oRd = '0; oEr = 1'b0; oRead = 0; oWrite = 0;
        oStrb = '0; oOut = '0; oAddr = '0;
        respDelay = dly;
        @(posedge clock);
        #1;
        while (!bus.req_ready && guard < 50) begin
            @(posedge clock);
            #1;
            guard++;
        end
        bus.req_valid   = 1'b1;
        bus.req_write   = wr;
        bus.req_size    = sz;
        bus.req_signext = sx;
        bus.req_addr    = a;
        bus.req_wdata   = wd;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clock);
            if (bus.DataMem_Read) begin
                oRead++;
                oAddr = bus.DataMem_Address;
            end
            if (bus.DataMem_Write != 4'b0000) begin
                oWrite++;
                oStrb = bus.DataMem_Write;
                oOut  = bus.DataMem_Out;
                oAddr = bus.DataMem_Address;
            end
            if (bus.rsp_valid) begin
                oLat = k;
                oRd  = bus.rsp_rdata;
                oEr  = bus.rsp_error;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] got [8];
        logic [31:0] want [8];
        reset = 1'b1;
        #2 reset = 1'b0;
        #1;
        got[0] = 32'(bus.req_ready);       want[0] = 32'd1;
        got[1] = 32'(bus.rsp_valid);       want[1] = 32'd0;
        got[2] = bus.rsp_rdata;            want[2] = 32'd0;
        got[3] = 32'(bus.rsp_error);       want[3] = 32'd0;
        got[4] = 32'(bus.DataMem_Read);    want[4] = 32'd0;
        got[5] = 32'(bus.DataMem_Write);   want[5] = 32'd0;
        got[6] = 32'(bus.DataMem_Address); want[6] = 32'd0;
        got[7] = bus.DataMem_Out;          want[7] = 32'd0;
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (got[i] !== want[i]) $display("FAIL reset_out%0d got %h want %h", i, got[i], want[i]);
            else passCount++;
        end
        repeat (2) @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_word_load();
        logic [31:0] exp;
        setWord(16, 32'hDEAD_BEEF);
        exp = modelLoad(2'b10, 1'b0, 32'h40);
        runReq(1'b0, 2'b10, 1'b0, 32'h40, '0, 0, lat, rd, er, nRd, nWr, strb, dout, waddr);
        checkCount++;
        if (rd !== exp) $display("FAIL word_load_data got %h want %h", rd, exp); else passCount++;
        checkCount++;
        if (er !== 1'b0) $display("FAIL word_load_err got %b want 0", er); else passCount++;
        checkCount++;
        if (lat !== 3) $display("FAIL word_load_latency got %0d want 3", lat); else passCount++;
        checkCount++;
        if (waddr !== 30'h10) $display("FAIL word_load_addr got %h want 10", waddr); else passCount++;
    endtask

    task automatic test_subword_loads();
        logic [31:0] exp;
        exp = modelLoad(2'b00, 1'b1, 32'h41);
        runReq(1'b0, 2'b00, 1'b1, 32'h41, '0, 0, lat, rd, er, nRd, nWr, strb, dout, waddr);
        checkCount++;
        if (rd !== exp) $display("FAIL byte_load_sext got %h want %h", rd, exp); else passCount++;
        exp = modelLoad(2'b01, 1'b0, 32'h42);
        runReq(1'b0, 2'b01, 1'b0, 32'h42, '0, 1, lat, rd, er, nRd, nWr, strb, dout, waddr);
        checkCount++;
        if (rd !== exp) $display("FAIL half_load_zext got %h want %h", rd, exp); else passCount++;
        checkCount++;
        if (lat !== 4) $display("FAIL half_load_latency got %0d want 4", lat); else passCount++;
    endtask

    task automatic test_stores();
        logic [1:0]  sz [2]   = '{2'b00, 2'b01};
        logic [31:0] addr [2] = '{32'h43, 32'h40};
        logic [31:0] wd [2]   = '{32'h5A, 32'h1234};
        logic [3:0]  expStrb;
        logic [31:0] expOut;
        for (int i = 0; i < 2; i++) begin
            expStrb = modelStrobe(sz[i], addr[i]);
            expOut  = modelOut(sz[i], wd[i]);
            modelStore(sz[i], addr[i], wd[i]);
            runReq(1'b1, sz[i], 1'b0, addr[i], wd[i], 0, lat, rd, er, nRd, nWr, strb, dout, waddr);
            checkCount++;
            if (strb !== expStrb || nWr !== 1 || nRd !== 0)
                $display("FAIL store%0d_strobe got %b x%0d rd%0d want %b x1 rd0",
                         i, strb, nWr, nRd, expStrb);
            else passCount++;
            checkCount++;
            if (dout !== expOut) $display("FAIL store%0d_out got %h want %h", i, dout, expOut);
            else passCount++;
            checkCount++;
            if (lat !== 2 || er !== 1'b0 || rd !== 32'd0)
                $display("FAIL store%0d_rsp got lat%0d err%b rd%h want lat2 err0 rd0",
                         i, lat, er, rd);
            else passCount++;
            checkCount++;
            if (busMem[16] !== refWord(16))
                $display("FAIL store%0d_mem got %h want %h", i, busMem[16], refWord(16));
            else passCount++;
        end
    endtask

    task automatic test_errors();
        logic        wr [3]   = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3]   = '{2'b10, 2'b01, 2'b11};
        logic [31:0] addr [3] = '{32'h42, 32'h41, 32'h40};
        for (int i = 0; i < 3; i++) begin
            runReq(wr[i], sz[i], 1'b0, addr[i], 32'hFFFF_FFFF, 0,
                   lat, rd, er, nRd, nWr, strb, dout, waddr);
            checkCount++;
            if (er !== 1'b1 || lat !== 1 || rd !== 32'd0)
                $display("FAIL error%0d_rsp got err%b lat%0d rd%h want err1 lat1 rd0",
                         i, er, lat, rd);
            else passCount++;
            checkCount++;
            if (nRd !== 0 || nWr !== 0)
                $display("FAIL error%0d_bus got rd%0d wr%0d want 0 0", i, nRd, nWr);
            else passCount++;
        end
    endtask

    task automatic test_timeout();
        logic [31:0] exp;
        int          stray;
        runReq(1'b0, 2'b10, 1'b0, 32'h40, '0, 1000, lat, rd, er, nRd, nWr, strb, dout, waddr);
        checkCount++;
        if (er !== 1'b1 || rd !== 32'd0)
            $display("FAIL timeout_rsp got err%b rd%h want err1 rd0", er, rd);
        else passCount++;
        checkCount++;
        if (lat !== TO + 1 || nRd !== TO)
            $display("FAIL timeout_latency got lat%0d rd%0d want lat%0d rd%0d",
                     lat, nRd, TO + 1, TO);
        else passCount++;
        stray = 0;
        forceJunk = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.rsp_valid) stray++;
        end
        forceJunk = 1'b0;
        checkCount++;
        if (stray !== 0) $display("FAIL late_ready_ignored got %0d pulses want 0", stray);
        else passCount++;
        exp = modelLoad(2'b01, 1'b1, 32'h40);
        runReq(1'b0, 2'b01, 1'b1, 32'h40, '0, 1, lat, rd, er, nRd, nWr, strb, dout, waddr);
        checkCount++;
        if (rd !== exp || er !== 1'b0 || lat !== 4)
            $display("FAIL after_timeout got rd%h err%b lat%0d want rd%h err0 lat4",
                     rd, er, lat, exp);
        else passCount++;
    endtask

    task automatic test_back_to_back();
        runReq(1'b1, 2'b10, 1'b0, 32'h80, 32'hCAFE_F00D, 0,
               lat, rd, er, nRd, nWr, strb, dout, waddr);
        modelStore(2'b10, 32'h80, 32'hCAFE_F00D);
        @(posedge clock);
        #1;
        checkCount++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0)
            $display("FAIL after_resp_idle got ready%b valid%b want 1 0",
                     bus.req_ready, bus.rsp_valid);
        else passCount++;
    endtask

    task automatic test_reset_mid_read();
        int   sawRsp;
        logic [31:0] exp;
        respDelay = 1000;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
        bus.req_signext = 1'b0; bus.req_addr = 32'h84;
        @(posedge clock);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clock);
        checkCount++;
        if (bus.DataMem_Read !== 1'b1) $display("FAIL midread_active got %b want 1", bus.DataMem_Read);
        else passCount++;
        #1 reset = 1'b0;
        #1;
        checkCount++;
        if (bus.DataMem_Read !== 1'b0 || bus.req_ready !== 1'b1)
            $display("FAIL midread_reset got read%b ready%b want 0 1",
                     bus.DataMem_Read, bus.req_ready);
        else passCount++;
        sawRsp = 0;
        repeat (2) begin
            @(negedge clock);
            if (bus.rsp_valid) sawRsp++;
        end
        reset = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (bus.rsp_valid) sawRsp++;
        end
        checkCount++;
        if (sawRsp !== 0 || bus.req_ready !== 1'b1)
            $display("FAIL midread_no_rsp got pulses%0d ready%b want 0 1", sawRsp, bus.req_ready);
        else passCount++;
        exp = modelLoad(2'b00, 1'b0, 32'h86);
        runReq(1'b0, 2'b00, 1'b0, 32'h86, '0, 0, lat, rd, er, nRd, nWr, strb, dout, waddr);
        checkCount++;
        if (rd !== exp || er !== 1'b0) $display("FAIL midread_recover got %h want %h", rd, exp);
        else passCount++;
    endtask

    task automatic test_random();
        logic        wr, sx;
        logic [1:0]  sz;
        logic [31:0] a, wd, expRd, expOut;
        logic [3:0]  expStrb;
        bit          err, to;
        int          dly, expLat, bad;
        for (int it = 0; it < 60; it++) begin
            wr = 1'($urandom_range(0, 1));
            sx = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if (sz != 2'b11 && $urandom_range(0, 3) != 0) a = a & ~32'(sizeBytes(sz) - 1);
            wd  = $urandom;
            dly = ($urandom_range(0, 7) == 0) ? 6 : $urandom_range(0, 2);
            err     = modelError(sz, a);
            to      = modelTimeout(wr, err, dly);
            expLat  = modelLatency(wr, err, dly);
            expRd   = (wr || err || to) ? 32'd0 : modelLoad(sz, sx, a);
            expStrb = modelStrobe(sz, a);
            expOut  = modelOut(sz, wd);
            if (wr && !err) modelStore(sz, a, wd);
            runReq(wr, sz, sx, a, wd, dly, lat, rd, er, nRd, nWr, strb, dout, waddr);
            checkCount++;
            if (rd !== expRd || er !== (err || to) || lat !== expLat)
                $display("FAIL rand%0d_rsp got rd%h err%b lat%0d want rd%h err%b lat%0d",
                         it, rd, er, lat, expRd, err || to, expLat);
            else passCount++;
            checkCount++;
            if (err) begin
                if (nRd !== 0 || nWr !== 0)
                    $display("FAIL rand%0d_quiet got rd%0d wr%0d want 0 0", it, nRd, nWr);
                else passCount++;
            end else if (wr) begin
                if (strb !== expStrb || dout !== expOut || nWr !== 1 || waddr !== a[31:2])
                    $display("FAIL rand%0d_store got %b %h x%0d @%h want %b %h x1 @%h",
                             it, strb, dout, nWr, waddr, expStrb, expOut, a[31:2]);
                else passCount++;
            end else begin
                if (waddr !== a[31:2] || nWr !== 0)
                    $display("FAIL rand%0d_load_addr got %h wr%0d want %h wr0",
                             it, waddr, nWr, a[31:2]);
                else passCount++;
            end
        end
        bad = 0;
        for (int i = 0; i < 64; i++) if (busMem[i] !== refWord(i)) bad++;
        checkCount++;
        if (bad !== 0) $display("FAIL rand_memory got %0d bad words want 0", bad);
        else passCount++;
    endtask

    initial begin
        reset           = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_size    = 2'b00;
        bus.req_signext = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        for (int i = 0; i < 64; i++) setWord(i, $urandom);
        test_reset();
        test_word_load();
        test_subword_loads();
        test_stores();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_read();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "simulation time limit");
    end
endmodule
